// File: rtl/axis_stream_shell.sv
// AXI-Stream adaptation shell: byte beats are packed MSB-first into source words,
// and sink words are buffered in a FIFO and serialised back into AXIS beats.
module axis_stream_shell #(
   parameter int AXIS_BYTES = 1,
   parameter int INP_WIDTH  = 16,
   parameter int OUT_WIDTH  = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [8*AXIS_BYTES-1:0]       s_axis_tdata,
   input  logic                          s_axis_tlast,
   output logic                          src_valid,
   input  logic                          src_ready,
   output logic [INP_WIDTH-1:0]          src,
   input  logic                          snk_valid,
   output logic                          snk_ready,
   input  logic [OUT_WIDTH-1:0]          snk,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [8*AXIS_BYTES-1:0]       m_axis_tdata,
   output logic                          m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   pad_count
);

   localparam int TDATA_W   = 8 * AXIS_BYTES;
   localparam int IN_BYTES  = INP_WIDTH / 8;
   localparam int OUT_BYTES = OUT_WIDTH / 8;
   localparam int IN_BEATS  = (IN_BYTES + AXIS_BYTES - 1) / AXIS_BYTES;
   localparam int OUT_BEATS = (OUT_BYTES + AXIS_BYTES - 1) / AXIS_BYTES;
   localparam int IN_CW     = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
   localparam int OUT_CW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
   localparam int SH_W      = OUT_BEATS * TDATA_W;
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int LW        = AW + 1;

   localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
   localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);

   typedef enum logic {IN_COLLECT, IN_DISPATCH} in_state_t;
   typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;

   // ---------------- input deserialiser ----------------
   in_state_t              r_in_state;
   logic                   r_s_ready;
   logic                   r_src_valid;
   logic [INP_WIDTH-1:0]   r_word;
   logic [IN_CW-1:0]       r_in_cnt;
   logic [15:0]            r_pad;

   logic                   w_in_fire;
   logic                   w_in_final;
   logic                   w_early;
   logic [INP_WIDTH-1:0]   w_word_next;

   assign w_in_fire  = s_axis_tvalid && r_s_ready;
   assign w_in_final = (r_in_cnt == IN_LAST) || s_axis_tlast;
   assign w_early    = s_axis_tlast && (r_in_cnt != IN_LAST);

   // Word byte k comes from beat k/AXIS_BYTES, lane k%AXIS_BYTES (lane 0 = MSB);
   // excess lanes of the final beat never map to a word byte and are dropped.
   always_comb begin
      w_word_next = r_word;
      for (int unsigned k = 0; k < IN_BYTES; k++) begin
         if (r_in_cnt == IN_CW'(k / AXIS_BYTES))
            w_word_next[INP_WIDTH-1-8*k -: 8] = s_axis_tdata[TDATA_W-1-8*(k % AXIS_BYTES) -: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_state  <= IN_COLLECT;
         r_s_ready   <= 1'b0;
         r_src_valid <= 1'b0;
         r_word      <= '0;
         r_in_cnt    <= '0;
         r_pad       <= '0;
      end else begin
         case (r_in_state)
            IN_COLLECT: begin
               r_s_ready <= 1'b1;
               if (w_in_fire) begin
                  r_word <= w_word_next;
                  if (w_in_final) begin
                     r_in_state  <= IN_DISPATCH;
                     r_s_ready   <= 1'b0;
                     r_src_valid <= 1'b1;
                     r_in_cnt    <= '0;
                     if (w_early && (r_pad != 16'hFFFF))
                        r_pad <= r_pad + 1'b1;
                  end else begin
                     r_in_cnt <= r_in_cnt + 1'b1;
                  end
               end
            end
            IN_DISPATCH: begin
               if (src_ready) begin
                  r_in_state  <= IN_COLLECT;
                  r_s_ready   <= 1'b1;
                  r_src_valid <= 1'b0;
                  // cleared so unfilled low bytes of the next word read as zero
                  r_word      <= '0;
               end
            end
            default: r_in_state <= IN_COLLECT;
         endcase
      end
   end

   // ---------------- output FIFO ----------------
   logic [OUT_WIDTH-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [LW-1:0]          r_level;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;

   assign w_full    = (r_level == LW'(FIFO_DEPTH));
   assign w_empty   = (r_level == '0);
   assign snk_ready = !w_full && !rst;
   assign w_push    = snk_valid && snk_ready;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= snk;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ---------------- output serialiser ----------------
   ser_state_t             r_ser_state;
   logic                   r_m_valid;
   logic                   r_m_last;
   logic [SH_W-1:0]        r_shift;
   logic [OUT_CW-1:0]      r_out_cnt;

   logic                   w_beat_done;
   logic                   w_word_done;
   logic [OUT_CW-1:0]      w_out_cnt_inc;
   logic [SH_W-1:0]        w_load;

   assign w_beat_done   = r_m_valid && m_axis_tready;
   assign w_word_done   = w_beat_done && (r_out_cnt == OUT_LAST);
   assign w_out_cnt_inc = r_out_cnt + 1'b1;
   // popping on the last beat's handshake keeps words back-to-back
   assign w_pop         = !w_empty && ((r_ser_state == SER_IDLE) || w_word_done);
   assign w_load        = SH_W'(r_mem[r_rd_ptr]) << (SH_W - OUT_WIDTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ser_state <= SER_IDLE;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_shift     <= '0;
         r_out_cnt   <= '0;
      end else if (w_pop) begin
         r_ser_state <= SER_SEND;
         r_m_valid   <= 1'b1;
         r_m_last    <= (OUT_BEATS == 1);
         r_shift     <= w_load;
         r_out_cnt   <= '0;
      end else if (w_word_done) begin
         r_ser_state <= SER_IDLE;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_shift     <= '0;
         r_out_cnt   <= '0;
      end else if (w_beat_done) begin
         r_shift     <= r_shift << TDATA_W;
         r_out_cnt   <= w_out_cnt_inc;
         r_m_last    <= (w_out_cnt_inc == OUT_LAST);
      end
   end

   assign s_axis_tready = r_s_ready;
   assign src_valid     = r_src_valid;
   assign src           = r_word;
   assign pad_count     = r_pad;
   assign fifo_level    = r_level;
   assign m_axis_tvalid = r_m_valid;
   assign m_axis_tlast  = r_m_last;
   assign m_axis_tdata  = r_shift[SH_W-1 -: TDATA_W];

endmodule

// File: doc/axis_stream_shell.md
Name: axis_stream_shell

Overview:
Parametrised AXI-Stream adaptation shell between a byte-granular AXIS link and the network source/sink word interfaces. Input beats are deserialised into INP_WIDTH source words, MSB-first, with tlast-framed partial-word padding. Output words are buffered in a FIFO and serialised into AXIS beats with per-word tlast. It supersedes the fixed single-beat processor wrapper by allowing arbitrary stream width, multi-beat words and output buffering.

Parameters:
AXIS_BYTES, 1, tdata width in bytes on both stream ports; TDATA_W = 8*AXIS_BYTES
INP_WIDTH, 16, source word width in bits, must be a multiple of 8; IN_BEATS = ceil((INP_WIDTH/8)/AXIS_BYTES)
OUT_WIDTH, 24, sink word width in bits, must be a multiple of 8; OUT_BEATS = ceil((OUT_WIDTH/8)/AXIS_BYTES)
FIFO_DEPTH, 4, output FIFO depth in words, power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tvalid  in  1  input stream valid
s_axis_tready  out  1  input stream ready
s_axis_tdata  in  TDATA_W  input beat
s_axis_tlast  in  1  input frame end
src_valid  out  1  source word valid
src_ready  in  1  source word ready
src  out  INP_WIDTH  assembled source word
snk_valid  in  1  sink word valid
snk_ready  out  1  sink word ready
snk  in  OUT_WIDTH  sink word
m_axis_tvalid  out  1  output stream valid
m_axis_tready  in  1  output stream ready
m_axis_tdata  out  TDATA_W  output beat
m_axis_tlast  out  1  last beat of each output word
fifo_level  out  $clog2(FIFO_DEPTH)+1  words held in output FIFO (excludes serialiser)
pad_count  out  16  number of partial input words padded, saturating

Behaviour:
- Reset: every output is 0; beat counters 0; partial input word discarded; FIFO emptied; serialiser idle; pad_count 0. Reset mid-word or mid-beat leaves no residue: the next accepted beat starts a fresh word.
- Input FSM, states COLLECT and DISPATCH. In COLLECT, s_axis_tready=1. Each accepted beat shifts into the word register MSB-first: the first beat is the most significant bytes.
- The FSM moves to DISPATCH when the beat count reaches IN_BEATS-1, or when tlast is seen on an earlier beat.
- Early tlast: the remaining low-order bytes are 0, so the data stays MSB-aligned, and pad_count increments (saturates at 0xFFFF). When IN_BEATS==1, tlast is ignored.
- If the final beat carries more bytes than the word needs, the excess low-order bytes are dropped.
- DISPATCH: src_valid=1 and s_axis_tready=0. src holds stable until src_ready; on handshake the FSM returns to COLLECT with the count cleared.
- Input latency: final beat accepted in cycle N gives src_valid=1 in cycle N+1. Throughput is one word per IN_BEATS+1 cycles minimum.
- Output FIFO: snk_ready = !full, registered-free, with no full bypass. A push happens on snk_valid&&snk_ready. Simultaneous push and pop is legal at any level, including full, where the pop frees a slot for the next cycle only. fifo_level updates on the same edge as the push or pop.
- Serialiser states: IDLE, SEND.
  - IDLE with FIFO non-empty: pop the word into a shift register and enter SEND with m_axis_tvalid=1.
  - SEND: m_axis_tdata carries the top TDATA_W bits of the word. The last beat's unused low bytes are 0. m_axis_tlast=1 only on beat OUT_BEATS-1.
  - On m_axis_tready&&m_axis_tvalid the FSM advances a beat. After the last beat it pops the next word directly if one is available (no bubble), otherwise it returns to IDLE.
- Output latency: snk handshake in cycle N into an empty, idle path gives m_axis_tvalid=1 in cycle N+2.
- AXIS rules: tvalid never depends combinationally on tready. tdata and tlast hold stable while tvalid&&!tready. Once asserted, tvalid drops only after the handshake.
- Capacity: FIFO_DEPTH words in the FIFO plus 1 in the serialiser.

Test Plan:
- Word assembly: AXIS_BYTES=1, INP_WIDTH=16; beats 0xAB then 0xCD (tlast=1), src_ready=1 -> src=0xABCD and src_valid=1 for exactly one cycle, starting 1 cycle after the 0xCD beat; pad_count=0.
- Early tlast: single beat 0x12 with tlast=1 -> src=0x1200, pad_count=1. Hold src_ready=0 for 5 cycles -> src stable and s_axis_tready=0 throughout.
- Output serialise: OUT_WIDTH=24, snk=0x123456, m_axis_tready=1 -> m_axis_tvalid at N+2; beats 0x12, 0x34, 0x56 on consecutive cycles; tlast only on 0x56. A back-to-back second word shows no idle cycle between words.
- Backpressure: m_axis_tready=0, push 6 words with FIFO_DEPTH=4 -> 5 accepted, snk_ready=0 after the 5th, fifo_level=4. m_axis_tdata holds the first word's MSB byte stable. Releasing tready drains all 5 words in order.
- Full with simultaneous push and pop: FIFO full, m_axis_tready=1 on a word boundary with snk_valid=1 -> snk_ready stays 0 that cycle, rises next cycle, and fifo_level returns to 4.
- Reset mid-operation: rst for 1 cycle after beat 0xAB and while SEND holds a word -> all outputs 0, fifo_level=0. Next beats 0x11, 0x22 (tlast) -> src=0x1122.
